vram_scanout: RTL and testbench
===============================

VRAM_SCANOUT -- requirements
Module: vram_scanout

Interface
Parameters:
REQ-001 The block SHALL have parameter L, default 32, meaning VRAM depth in pixels.
REQ-002 The block SHALL have parameter DISPLAY_WIDTH, default 240, meaning pixels per row.
REQ-003 The block SHALL have parameter DISPLAY_HEIGHT, default 320, meaning rows per frame.

Ports:
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on posedge clk.
REQ-005 The block SHALL have port rst, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit, a frame-scan request.
REQ-007 The block SHALL have port busy, output, 1 bit, meaning a scan is in progress.
REQ-008 The block SHALL have port rd_addr, output, $clog2(L) bits, the VRAM read address.
REQ-009 The block SHALL have port rd_ena, output, 1 bit, the VRAM read strobe.
REQ-010 The block SHALL have port rd_data, input, ILI9341_color_t, the VRAM read data, valid exactly 1 cycle after rd_ena.
REQ-011 The block SHALL have port pixel_data, output, ILI9341_color_t, the pixel to the display driver.
REQ-012 The block SHALL have port pixel_valid, output, 1 bit, meaning pixel_data is valid.
REQ-013 The block SHALL have port pixel_ready, input, 1 bit, the display-driver accept signal.
REQ-014 The block SHALL have port pixel_first, output, 1 bit, which is high with the pixel at address 0.
REQ-015 The block SHALL have port frame_done, output, 1 bit, a 1-cycle pulse after the last pixel is accepted.

Function
REQ-016 The scan SHALL cover NPIX = min(L, DISPLAY_WIDTH*DISPLAY_HEIGHT) pixels in row-major order, addresses 0..NPIX-1, with address = y*DISPLAY_WIDTH + x, matching the writer's layout.
REQ-017 The FSM states SHALL be S_IDLE, S_FETCH, S_DRAIN and S_DONE.
REQ-018 In S_IDLE, start=1 SHALL reset the address counter to 0 and go to S_FETCH on the next edge; start in any other state SHALL be ignored.
REQ-019 The block SHALL contain a 2-entry pixel FIFO; rd_ena SHALL assert only when (FIFO occupancy + reads in flight) < 2, so no read data is ever dropped.
REQ-020 Each rd_ena=1 cycle SHALL increment the address counter by 1; rd_addr SHALL equal the counter while rd_ena=1 and SHALL be 0 otherwise.
REQ-021 Read data SHALL be written into the FIFO on the cycle after rd_ena, regardless of pixel_ready.
REQ-022 pixel_valid SHALL equal FIFO not-empty; pixel_data and pixel_first SHALL be the FIFO head.
REQ-023 A transfer SHALL occur when pixel_valid && pixel_ready; the head SHALL stay stable while pixel_valid=1 and pixel_ready=0.
REQ-024 A simultaneous FIFO push and pop SHALL be supported in the same cycle, keeping occupancy unchanged.
REQ-025 When the read of address NPIX-1 issues, the FSM SHALL go to S_DRAIN; no further reads SHALL issue.
REQ-026 In S_DRAIN, when the last pixel transfers, the FSM SHALL go to S_DONE; in S_DONE, frame_done SHALL be 1 for exactly one cycle, then the FSM returns to S_IDLE.
REQ-027 busy SHALL be 1 in S_FETCH, S_DRAIN and S_DONE, and 0 in S_IDLE.
REQ-028 With pixel_ready held at 1, sustained throughput SHALL be 1 pixel/cycle after a first-pixel latency of 2 cycles from start.
REQ-029 The address counter SHALL never exceed NPIX-1 and SHALL not wrap within a frame.

Reset
REQ-030 rst=0 SHALL immediately force: state S_IDLE, counter 0, FIFO empty, in-flight flag 0, busy=0, rd_ena=0, rd_addr=0, pixel_valid=0, pixel_first=0, frame_done=0, pixel_data=0.
REQ-031 A reset asserted mid-frame SHALL abort the frame with no frame_done; the next start after release SHALL begin at address 0.

Verification (L=8, DISPLAY_WIDTH=4, DISPLAY_HEIGHT=2, VRAM[i]=16'h0100+i)
REQ-032 Scenario: start pulse, pixel_ready=1 -> pixels 0x0100..0x0107 on 8 consecutive cycles starting 2 cycles after start; pixel_first only on 0x0100; one frame_done pulse; busy then returns to 0.
REQ-033 Scenario: pixel_ready toggling 1,0,0,1,... -> every pixel delivered once, in order, with none lost or duplicated; pixel_data stable while stalled; rd_ena never issued with 2 pixels outstanding.
REQ-034 Scenario: pixel_ready=0 for 20 cycles after start -> FIFO holds 0x0100 and 0x0101, rd_ena=0, counter=2; after release the rest of the frame completes.
REQ-035 Scenario: start re-pulsed during a frame -> ignored, exactly 8 pixels and one frame_done.
REQ-036 Scenario: rst=0 after the 3rd pixel -> all outputs at reset values asynchronously; a new start yields 0x0100 first.
REQ-037 Scenario: L=4 with a 4x2 display -> NPIX=4, last rd_addr=3, frame_done after 0x0103.

Source files
------------

// File: rtl/vram_scanout.sv
// vram_scanout: streams one frame of pixels out of a VRAM in row-major order to a
// display driver over a valid/ready handshake.
//
// The VRAM has a fixed one-cycle read latency. A 2-entry pixel FIFO absorbs that
// latency, so the driver can stall at any time without losing read data.
//
// Ports:
//   clk          single clock, all state on posedge
//   rst          asynchronous active-low reset
//   start        frame-scan request, only honoured while idle
//   busy         high from the first fetch until the frame_done cycle inclusive
//   rd_addr      VRAM read address; 0 whenever rd_ena is low
//   rd_ena       VRAM read strobe
//   rd_data      VRAM read data (ILI9341 16-bit RGB565), valid one cycle after rd_ena
//   pixel_data   FIFO head pixel to the display driver
//   pixel_valid  FIFO not empty
//   pixel_ready  driver accepts pixel_data this cycle
//   pixel_first  head pixel came from address 0
//   frame_done   one-cycle pulse after the last pixel of the frame is accepted
module vram_scanout #(
  parameter int unsigned L              = 32,
  parameter int unsigned DISPLAY_WIDTH  = 240,
  parameter int unsigned DISPLAY_HEIGHT = 320
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic [$clog2(L)-1:0] rd_addr,
  output logic                 rd_ena,
  input  logic [15:0]          rd_data,
  output logic [15:0]          pixel_data,
  output logic                 pixel_valid,
  input  logic                 pixel_ready,
  output logic                 pixel_first,
  output logic                 frame_done
);

  localparam int unsigned AW        = $clog2(L);
  localparam int unsigned FRAME_PIX = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam int unsigned NPIX      = (L < FRAME_PIX) ? L : FRAME_PIX;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic          r_busy;
  logic          r_done;

  // One read may be in flight; its first-pixel tag travels with it.
  logic          r_inflight;
  logic          r_inflight_first;

  // 2-entry FIFO of {first, data}.
  logic [15:0]   r_mem_data [2];
  logic          r_mem_first [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;

  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_pending;
  logic          w_rd_ena;
  logic          w_last_read;
  logic          w_last_pop;

  assign pixel_valid = (r_count != 2'd0);
  assign w_pop       = pixel_valid & pixel_ready;
  assign w_push      = r_inflight;

  // Entries that will still be held once this cycle's pop leaves. Counting the pop
  // lets a read issue every cycle while the driver keeps up, yet the FIFO plus the
  // in-flight read never exceeds two pixels.
  assign w_pending   = r_count + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_rd_ena    = (r_state == S_FETCH) && (w_pending < 2'd2);
  assign w_last_read = w_rd_ena && (r_addr == LAST_ADDR);

  // The last pixel leaves when the FIFO holds exactly one entry and nothing is
  // still on its way from the VRAM.
  assign w_last_pop  = (r_state == S_DRAIN) && w_pop && (r_count == 2'd1) && !r_inflight;

  assign rd_ena      = w_rd_ena;
  assign rd_addr     = w_rd_ena ? r_addr : '0;
  assign busy        = r_busy;
  assign frame_done  = r_done;
  assign pixel_data  = r_mem_data[r_rd_ptr];
  assign pixel_first = pixel_valid & r_mem_first[r_rd_ptr];

  // Frame sequencing. busy and frame_done are registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_rd_ena) begin
            // Counter saturates on the last address so it never wraps.
            if (w_last_read) begin
              r_state <= S_DRAIN;
            end else begin
              r_addr <= r_addr + AW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (w_last_pop) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read pipeline and pixel FIFO. Read data is captured unconditionally on the
  // cycle after the strobe; the issue rule guarantees there is room for it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inflight       <= 1'b0;
      r_inflight_first <= 1'b0;
      r_wr_ptr         <= 1'b0;
      r_rd_ptr         <= 1'b0;
      r_count          <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_mem_data[i]  <= 16'h0000;
        r_mem_first[i] <= 1'b0;
      end
    end else begin
      r_inflight       <= w_rd_ena;
      r_inflight_first <= w_rd_ena && (r_addr == '0);
      if (w_push) begin
        r_mem_data[r_wr_ptr]  <= rd_data;
        r_mem_first[r_wr_ptr] <= r_inflight_first;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_scanout.sv
// Self-checking bench for vram_scanout. Two instances: an 8-pixel frame (L=8, 4x2)
// and a VRAM-limited 4-pixel frame (L=4, 4x2). VRAM[i] = 0x0100 + i.
module tb_vram_scanout;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic sel = 1'b0;

  always #5 clk = ~clk;

  logic        start_a, start_b;
  logic        a_busy, a_rd_ena, a_valid, a_first, a_done;
  logic [2:0]  a_rd_addr;
  logic [15:0] a_rd_data, a_pix;
  logic        b_busy, b_rd_ena, b_valid, b_first, b_done;
  logic [1:0]  b_rd_addr;
  logic [15:0] b_rd_data, b_pix;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  vram_scanout #(.L(8), .DISPLAY_WIDTH(4), .DISPLAY_HEIGHT(2)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(a_busy), .rd_addr(a_rd_addr),
    .rd_ena(a_rd_ena), .rd_data(a_rd_data), .pixel_data(a_pix), .pixel_valid(a_valid),
    .pixel_ready(ready), .pixel_first(a_first), .frame_done(a_done)
  );

  vram_scanout #(.L(4), .DISPLAY_WIDTH(4), .DISPLAY_HEIGHT(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(b_busy), .rd_addr(b_rd_addr),
    .rd_ena(b_rd_ena), .rd_data(b_rd_data), .pixel_data(b_pix), .pixel_valid(b_valid),
    .pixel_ready(ready), .pixel_first(b_first), .frame_done(b_done)
  );

  // VRAM models: one-cycle read latency, garbage when not strobed.
  always @(posedge clk) a_rd_data <= a_rd_ena ? 16'h0100 + 16'(a_rd_addr) : 16'hDEAD;
  always @(posedge clk) b_rd_data <= b_rd_ena ? 16'h0100 + 16'(b_rd_addr) : 16'hDEAD;

  // View of whichever instance is under test.
  logic        m_busy, m_rd_ena, m_valid, m_first, m_done;
  int          m_rd_addr;
  logic [15:0] m_pix;
  always_comb begin
    m_busy    = sel ? b_busy : a_busy;
    m_rd_ena  = sel ? b_rd_ena : a_rd_ena;
    m_valid   = sel ? b_valid : a_valid;
    m_first   = sel ? b_first : a_first;
    m_done    = sel ? b_done : a_done;
    m_rd_addr = sel ? int'(b_rd_addr) : int'(a_rd_addr);
    m_pix     = sel ? b_pix : a_pix;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h) at %0t",
               tag, obs, obs, exp, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Ready pattern: 0 always on, 1 repeating 1,0,0, 2 random, 3 held off.
  int mode = 0;
  int pat  = 0;
  always @(posedge clk) begin
    #1;
    case (mode)
      0:       ready = 1'b1;
      1:       begin ready = (pat % 3 == 0); pat++; end
      2:       ready = 1'($urandom_range(0, 1));
      default: ready = 1'b0;
    endcase
  end

  // Reference model: the frame is the address sequence 0..npix-1, read in order
  // and delivered in order; at most two pixels may be owed to the driver.
  int          npix = 8;
  int          exp_idx = 0;
  int          rd_idx = 0;
  int          n_done = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = 16'h0;

  always @(negedge clk) begin
    if (!rst) begin
      exp_idx    = 0;
      rd_idx     = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_val("stall_keeps_valid", 32'(m_valid), 32'd1);
        check_val("stall_keeps_data", 32'(m_pix), 32'(prev_data));
      end
      if (m_rd_ena) begin
        check_val("rd_addr", m_rd_addr, rd_idx);
        check_val("rd_in_range", 32'(rd_idx < npix), 32'd1);
        check_val("outstanding_lt2",
                  32'((rd_idx - exp_idx - int'(m_valid && ready)) < 2), 32'd1);
        rd_idx++;
      end else begin
        check_val("rd_addr_idle", m_rd_addr, 0);
      end
      if (m_valid && ready) begin
        check_val("pix_data", 32'(m_pix), 32'h0100 + exp_idx);
        check_val("pix_first", 32'(m_first), 32'(exp_idx == 0));
        check_val("pix_in_frame", 32'(exp_idx < npix), 32'd1);
        exp_idx++;
      end
      prev_stall = m_valid && !ready;
      prev_data  = m_pix;
      if (m_done) begin
        n_done++;
        check_val("done_pixel_count", exp_idx, npix);
        check_val("done_read_count", rd_idx, npix);
        exp_idx = 0;
        rd_idx  = 0;
      end
    end
  end

  task automatic check_reset_values();
    check_val("rst_busy", 32'(a_busy), 32'd0);
    check_val("rst_rd_ena", 32'(a_rd_ena), 32'd0);
    check_val("rst_rd_addr", 32'(a_rd_addr), 32'd0);
    check_val("rst_valid", 32'(a_valid), 32'd0);
    check_val("rst_first", 32'(a_first), 32'd0);
    check_val("rst_done", 32'(a_done), 32'd0);
    check_val("rst_pix", 32'(a_pix), 32'd0);
    check_val("rst_b_busy", 32'(b_busy), 32'd0);
    check_val("rst_b_valid", 32'(b_valid), 32'd0);
  endtask

  // Returns the cycle number (cyc) at which start is sampled.
  task automatic pulse_start(output int t0);
    @(posedge clk);
    #1;
    start = 1'b1;
    t0 = cyc + 1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_first(input int t0);
    bit got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_valid) begin
        got = 1'b1;
        break;
      end
    end
    check_val("first_latency", got ? 32'(cyc - t0) : 32'hFFFF_FFFF, 32'd2);
    check_val("busy_running", 32'(m_busy), 32'd1);
  endtask

  task automatic wait_done(input bit repulse, output int done_cyc);
    bit got = 1'b0;
    done_cyc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (repulse && i == 2) start = 1'b1;
      if (i == 3) start = 1'b0;
      if (m_done) begin
        got = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
    start = 1'b0;
    check_val("frame_done_seen", 32'(got), 32'd1);
  endtask

  task automatic finish_frame(input int dn0);
    repeat (3) @(negedge clk);
    check_val("done_pulses", n_done - dn0, 1);
    check_val("idle_busy", 32'(m_busy), 32'd0);
    check_val("idle_valid", 32'(m_valid), 32'd0);
  endtask

  task automatic run_frame(input bit s, input int mode_i, input bit repulse);
    int t0, dn0, done_cyc;
    sel  = s;
    npix = s ? 4 : 8;
    mode = mode_i;
    dn0  = n_done;
    pulse_start(t0);
    wait_first(t0);
    wait_done(repulse, done_cyc);
    if (mode_i == 0) check_val("throughput", done_cyc - t0, 2 + npix);
    finish_frame(dn0);
  endtask

  initial begin
    int t0, dn0, done_cyc;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b1;

    // Full-speed frame, driver pattern 1,0,0, and a re-pulsed start.
    run_frame(1'b0, 0, 1'b0);
    run_frame(1'b0, 1, 1'b0);
    run_frame(1'b0, 0, 1'b1);

    // Driver stalled for 20 cycles: FIFO full with pixels 0 and 1, reads stop.
    sel  = 1'b0;
    npix = 8;
    mode = 3;
    dn0  = n_done;
    pulse_start(t0);
    repeat (20) @(negedge clk);
    check_val("hold_rd_ena", 32'(m_rd_ena), 32'd0);
    check_val("hold_valid", 32'(m_valid), 32'd1);
    check_val("hold_head", 32'(m_pix), 32'h0100);
    check_val("hold_reads", rd_idx, 2);
    mode = 0;
    wait_done(1'b0, done_cyc);
    finish_frame(dn0);

    // Reset after the third accepted pixel aborts the frame without frame_done.
    sel  = 1'b0;
    npix = 8;
    mode = 0;
    dn0  = n_done;
    pulse_start(t0);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (exp_idx >= 3) break;
    end
    #2;
    rst = 1'b0;
    #1;
    check_reset_values();
    repeat (3) @(negedge clk);
    check_val("abort_no_done", n_done - dn0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_frame(1'b0, 0, 1'b0);

    // VRAM smaller than the display: only 4 pixels.
    run_frame(1'b1, 0, 1'b0);
    run_frame(1'b1, 1, 1'b1);

    // Randomised driver backpressure on both instances.
    for (int k = 0; k < 8; k++) begin
      run_frame(k[0], 2, k == 5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
